// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    // Per-word status carried through the FIFO alongside the payload.
    typedef struct packed {
        logic brk;
        logic frame_err;
        logic parity_err;
    } rx_flags_t;

    // Rounded clocks per oversample tick, never below 1.
    function automatic int unsigned baud_div(input int unsigned clk,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned den;
        int unsigned q;
        den = baud * os;
        if (den == 0) return 1;
        q = (clk + den / 2) / den;
        return (q == 0) ? 1 : q;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Received-word stream from the UART receiver to its consumer.
interface uart_rx_core_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, break_det, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; a pop in the same cycle lets a push into a full FIFO.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: sync, oversample tick, 3-sample vote, frame FSM,
// and a word FIFO feeding a valid/ready stream.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned BAUD_RATE   = 9_600,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rxd,
    uart_rx_core_if.master rx
);
    localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned S_W   = $clog2(OVERSAMPLE);
    localparam int unsigned B_W   = $clog2(DATA_BITS + 1);
    localparam int unsigned M     = OVERSAMPLE / 2;
    localparam int unsigned W_W   = DATA_BITS + 3;

    rx_state_t            state;
    logic                 sync1;
    logic                 sync2;
    logic                 rxd_prev;
    logic [CNT_W-1:0]     tick_cnt;
    logic [S_W-1:0]       s_cnt;
    logic [B_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] data;
    logic                 samp_a;
    logic                 samp_b;
    logic                 par_bit;
    logic                 par_err;
    logic                 stop_zero;
    logic                 stop_one;
    logic                 busy_q;
    logic                 overrun_q;

    logic                 tick_c;
    logic                 start_edge_c;
    logic                 vote_c;
    logic                 vote_pt_c;
    logic                 bit_end_c;
    logic                 exp_par_c;
    logic                 last_stop_c;
    logic                 stop_one_c;
    logic                 brk_c;
    logic                 push_c;
    logic                 pop_c;
    rx_flags_t            flags_c;
    rx_flags_t            head_flags;
    logic [W_W-1:0]       fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            sync1    <= rxd;
            sync2    <= sync1;
            rxd_prev <= sync2;
        end
    end

    assign start_edge_c = (state == IDLE) && !sync2 && rxd_prev;
    assign tick_c       = (tick_cnt == CNT_W'(DIV - 1));

    // Tick divider, re-phased on every detected start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         tick_cnt <= '0;
        else if (start_edge_c || tick_c) tick_cnt <= '0;
        else                             tick_cnt <= tick_cnt + CNT_W'(1);
    end

    assign vote_c      = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
    assign vote_pt_c   = tick_c && (s_cnt == S_W'(M + 1));
    assign bit_end_c   = tick_c && (s_cnt == S_W'(OVERSAMPLE - 1));
    assign exp_par_c   = (PARITY_MODE == PAR_ODD) ? ~(^data) : (^data);
    assign last_stop_c = (bit_cnt == B_W'(STOP_BITS - 1));
    assign stop_one_c  = stop_one | vote_c;
    assign brk_c       = (data == '0) && !par_bit && !stop_one_c;
    assign push_c      = (state == STOP) && vote_pt_c && last_stop_c;

    assign flags_c.brk        = brk_c;
    assign flags_c.frame_err  = stop_zero | ~vote_c;
    assign flags_c.parity_err = par_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s_cnt     <= '0;
            bit_cnt   <= '0;
            data      <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            stop_zero <= 1'b0;
            stop_one  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (tick_c && (s_cnt == S_W'(M - 1))) samp_a <= sync2;
            if (tick_c && (s_cnt == S_W'(M)))     samp_b <= sync2;
            case (state)
                IDLE: begin
                    s_cnt     <= '0;
                    bit_cnt   <= '0;
                    par_bit   <= 1'b0;
                    par_err   <= 1'b0;
                    stop_zero <= 1'b0;
                    stop_one  <= 1'b0;
                    if (start_edge_c) begin
                        state  <= START;
                        busy_q <= 1'b1;
                    end
                end
                START: if (tick_c) begin
                    s_cnt <= s_cnt + S_W'(1);
                    if (vote_pt_c && vote_c) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (bit_end_c) begin
                        state <= DATA;
                        s_cnt <= '0;
                    end
                end
                DATA: if (tick_c) begin
                    s_cnt <= s_cnt + S_W'(1);
                    if (vote_pt_c) data <= {vote_c, data[DATA_BITS-1:1]};
                    if (bit_end_c) begin
                        s_cnt   <= '0;
                        bit_cnt <= bit_cnt + B_W'(1);
                        if (bit_cnt == B_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: if (tick_c) begin
                    s_cnt <= s_cnt + S_W'(1);
                    if (vote_pt_c) begin
                        par_bit <= vote_c;
                        par_err <= (vote_c != exp_par_c);
                    end
                    if (bit_end_c) begin
                        s_cnt <= '0;
                        state <= STOP;
                    end
                end
                STOP: if (tick_c) begin
                    s_cnt <= s_cnt + S_W'(1);
                    // Last stop vote ends the frame early so a back-to-back start is caught.
                    if (vote_pt_c && last_stop_c) begin
                        state   <= brk_c ? BRK_WAIT : IDLE;
                        busy_q  <= brk_c;
                        s_cnt   <= '0;
                        bit_cnt <= '0;
                    end else begin
                        if (vote_pt_c) begin
                            stop_zero <= stop_zero | ~vote_c;
                            stop_one  <= stop_one_c;
                        end
                        if (bit_end_c) begin
                            s_cnt   <= '0;
                            bit_cnt <= bit_cnt + B_W'(1);
                        end
                    end
                end
                BRK_WAIT: if (sync2) begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign pop_c = rx.rx_valid && rx.rx_ready;

    // A push into a full FIFO without a same-cycle pop is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= push_c && fifo_full && !pop_c;
    end

    sync_fifo #(
        .WIDTH (W_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .din   ({flags_c, data}),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_flags    = fifo_dout[W_W-1 -: 3];
    assign rx.rx_data    = fifo_dout[DATA_BITS-1:0];
    assign rx.rx_valid   = !fifo_empty;
    assign rx.parity_err = head_flags.parity_err;
    assign rx.frame_err  = head_flags.frame_err;
    assign rx.break_det  = head_flags.brk;
    assign rx.overrun    = overrun_q;
    assign rx.busy       = busy_q;
endmodule
